// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROD_W = 2 * XLEN;

    localparam logic [XLEN-1:0] DIV0_QUOTIENT = '1;
    localparam logic [XLEN-1:0] SIGNED_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // Remainder-producing divide ops (REM/REMU)
    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bus of the multiply/divide unit: op request, flush, stall and result.
interface ex_muldiv_unit_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, op_a, op_b, flush,
        input  busy, stall_req, done, result
    );

    modport slave (
        input  start, op, op_a, op_b, flush,
        output busy, stall_req, done, result
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; gives magnitudes on the way in, signed results on the way out.
module muldiv_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide with stall and done handshake.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier for ops 0-3.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    ex_muldiv_unit_if.slave bus
);

    md_state_e         state, state_n;
    md_op_e            op_q, op_n;
    logic [PROD_W-1:0] acc, acc_n;
    logic [XLEN-1:0]   opnd, opnd_n;
    logic              neg_res, neg_res_n;
    logic              neg_rem, neg_rem_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [XLEN-1:0]   result_q, result_n;
    logic              busy_q, done_q, done_n;

    // Input side: operand magnitudes and result sign flags
    md_op_e          op_in;
    logic            a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign op_in = md_op_e'(bus.op);
    assign a_neg = op_a_signed(op_in) & bus.op_a[XLEN-1];
    assign b_neg = op_b_signed(op_in) & bus.op_b[XLEN-1];
    assign div0  = op_is_div(op_in) && (bus.op_b == '0);
    assign ovf   = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                   (bus.op_a == SIGNED_MIN) && (bus.op_b == '1);

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (.val(bus.op_a), .neg(a_neg), .res(mag_a));
    muldiv_sign_fix #(.W(XLEN)) u_fix_b (.val(bus.op_b), .neg(b_neg), .res(mag_b));

    always_comb begin
        if (div0) fast_res = op_is_rem(op_in) ? bus.op_a : DIV0_QUOTIENT;
        else      fast_res = op_is_rem(op_in) ? '0 : SIGNED_MIN;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [PROD_W-1:0] fast_prod_mag, fast_prod;
    logic [XLEN-1:0]   fast_mul_res;

    assign fast_prod_mag = PROD_W'(mag_a) * PROD_W'(mag_b);
    muldiv_sign_fix #(.W(PROD_W)) u_fix_fast (.val(fast_prod_mag), .neg(a_neg ^ b_neg), .res(fast_prod));
    assign fast_mul_res = (op_in == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[PROD_W-1:XLEN];
`endif

    // One iteration step; acc holds {product hi, multiplier} or {remainder, dividend/quotient}
    logic [XLEN-1:0]   acc_hi, acc_lo, div_diff;
    logic [XLEN:0]     mul_sum, div_trial;
    logic              div_ge;
    logic [PROD_W-1:0] step_acc;

    assign acc_hi    = acc[PROD_W-1:XLEN];
    assign acc_lo    = acc[XLEN-1:0];
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_trial = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, opnd};
    assign div_diff  = div_trial[XLEN-1:0] - opnd;

    always_comb begin
        if (!op_is_div(op_q))  step_acc = {mul_sum, acc_lo[XLEN-1:1]};
        else if (div_ge)       step_acc = {div_diff, acc_lo[XLEN-2:0], 1'b1};
        else                   step_acc = {div_trial[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    end

    // Output side: sign-corrected product, quotient and remainder of the final step
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    muldiv_sign_fix #(.W(PROD_W)) u_fix_prod (.val(step_acc), .neg(neg_res), .res(prod_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_quo  (.val(step_acc[XLEN-1:0]), .neg(neg_res), .res(quo_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_rem  (.val(step_acc[PROD_W-1:XLEN]), .neg(neg_rem), .res(rem_fix));

    always_comb begin
        unique case (op_q)
            MD_MUL:                     final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[PROD_W-1:XLEN];
            MD_DIV, MD_DIVU:            final_res = quo_fix;
            default:                    final_res = rem_fix;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        op_n      = op_q;
        acc_n     = acc;
        opnd_n    = opnd;
        neg_res_n = neg_res;
        neg_rem_n = neg_rem;
        cnt_n     = cnt;
        result_n  = result_q;
        done_n    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_n      = op_in;
                    opnd_n    = op_is_div(op_in) ? mag_b : mag_a;
                    acc_n     = {XLEN'(0), (op_is_div(op_in) ? mag_a : mag_b)};
                    neg_res_n = a_neg ^ b_neg;
                    neg_rem_n = a_neg;
                    cnt_n     = '0;
                    if (div0 || ovf) begin
                        result_n = fast_res;
                        state_n  = ST_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_is_div(op_in)) begin
                        result_n = fast_mul_res;
                        state_n  = ST_DONE;
                    end
`endif
                    else begin
                        state_n = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_n = step_acc;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(XLEN - 1)) begin
                    result_n = final_res;
                    state_n  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_n  = ST_IDLE;
            result_n = '0;
            done_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= MD_MUL;
            acc      <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_n;
            acc      <= acc_n;
            opnd     <= opnd_n;
            neg_res  <= neg_res_n;
            neg_rem  <= neg_rem_n;
            cnt      <= cnt_n;
            result_q <= result_n;
            busy_q   <= (state_n != ST_IDLE);
            done_q   <= done_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.stall_req = ((state == ST_IDLE) && bus.start && !bus.flush) || (state == ST_CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        logic               of;
        sa = a;
        sb = b;
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        of = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0:    r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4:    r = (b == 0) ? 32'hFFFF_FFFF : (of ? 32'h8000_0000 : 32'(sa / sb));
            3'd5:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    r = (b == 0) ? a : (of ? 32'h0 : 32'(sa % sb));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from the start edge until done is seen
    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] exp;
        int          lat, k;
        bit          got, busy_ok;
        exp = ref_model(op, a, b);
        lat = lat_of(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        #1 check("stall_on_start", 32'(bus.stall_req), 32'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        k = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && k < 80) begin
            @(posedge clk);
            #1 k++;
            if (poke && k == 5) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.op_a  = ~a;
                bus.op_b  = b + 32'd1;
            end
            if (poke && k == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) got = 1'b1;
            else if (k < lat && bus.busy !== 1'b1) busy_ok = 1'b0;
            else if (k < lat - 1 && bus.stall_req !== 1'b1) busy_ok = 1'b0;
        end
        check($sformatf("latency op%0d", op), 32'(k), 32'(lat));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), bus.result, exp);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("busy_stall_while_calc", 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1 check("done_one_cycle", 32'(bus.done), 32'd0);
        check("result_held", bus.result, exp);
    endtask

    initial begin
        int dcount;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;

        #2;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul_7x-3_const", bus.result, 32'hFFFF_FFEB);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulhu_const", bus.result, 32'hFFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulh_const", bus.result, 32'h0);
        do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 1'b0);
        check("div_-20/3_const", bus.result, 32'hFFFF_FFFA);
        do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 1'b0);
        check("rem_-20/3_const", bus.result, 32'hFFFF_FFFE);
        do_op(3'd5, 32'd5, 32'd0, 1'b0);
        check("divu_by0_const", bus.result, 32'hFFFF_FFFF);
        do_op(3'd6, 32'd5, 32'd0, 1'b0);
        check("rem_by0_const", bus.result, 32'd5);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_const", bus.result, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("rem_ovf_const", bus.result, 32'h0);
        do_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd7, 32'd1000, 32'd7, 1'b0);

        // Start while calculating must not restart the op
        do_op(3'd5, 32'd1234567, 32'd89, 1'b1);

        // Flush in CALC cycle 10
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_result", bus.result, 32'd0);
        check("flush_stall", 32'(bus.stall_req), 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.done === 1'b1) dcount++;
        end
        check("flush_no_done", 32'(dcount), 32'd0);

        // Start together with flush stays idle
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4;
        #1 check("start_flush_stall", 32'(bus.stall_req), 32'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_busy", 32'(bus.busy), 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.done === 1'b1) dcount++;
        end
        check("start_flush_no_done", 32'(dcount), 32'd0);

        // Async reset mid-CALC
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.op_a = 32'd999; bus.op_b = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random ops with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
